// File: rtl/dmem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pipe
// Brief    : Single-port data memory with a LAT-cycle read pipeline, driven by
//            an IDLE/WAIT/RESP FSM. Optional macro DMEM_BYTE_EN_EN enables
//            byte-masked writes; by default every write updates the full word.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_pipe #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W/8-1:0] be,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = (LAT > 1) ? CNT_W'(LAT - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              w_acc;
  logic              w_wr_en;
  logic [NB-1:0]     w_wbe;

  assign w_acc   = req & ready_q;
  assign w_wr_en = w_acc & wr & ~rst;

`ifdef DMEM_BYTE_EN_EN
  assign w_wbe = be;
`else
  logic w_unused_be;
  assign w_wbe       = '1;
  assign w_unused_be = ^be;
`endif

  // The array has no reset so that contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wbe[b]) begin
          mem_q[addr][8*b +: 8] <= din[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      dout_q   <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (w_acc && !wr) begin
            rdata_q <= mem_q[addr];
            if (LAT == 1) begin
              state_q  <= S_RESP;
              rvalid_q <= 1'b1;
              dout_q   <= mem_q[addr];
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
              ready_q <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= S_RESP;
            rvalid_q <= 1'b1;
            dout_q   <= rdata_q;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign dout   = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_pipe
// Brief    : Directed self-checking bench; four dmem_pipe instances with
//            LAT = 2, 1, 4, 3 on a shared clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_pipe;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req, wr, ready, rvalid;
  logic [3:0][5:0]  addr;
  logic [3:0][31:0] din, dout;
  logic [3:0][3:0]  be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_pipe #(.ADDR_W(6), .DATA_W(32), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .din(din[0]),
    .be(be[0]), .ready(ready[0]), .rvalid(rvalid[0]), .dout(dout[0]));
  dmem_pipe #(.ADDR_W(6), .DATA_W(32), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .din(din[1]),
    .be(be[1]), .ready(ready[1]), .rvalid(rvalid[1]), .dout(dout[1]));
  dmem_pipe #(.ADDR_W(6), .DATA_W(32), .LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .req(req[2]), .wr(wr[2]), .addr(addr[2]), .din(din[2]),
    .be(be[2]), .ready(ready[2]), .rvalid(rvalid[2]), .dout(dout[2]));
  dmem_pipe #(.ADDR_W(6), .DATA_W(32), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .req(req[3]), .wr(wr[3]), .addr(addr[3]), .din(din[3]),
    .be(be[3]), .ready(ready[3]), .rvalid(rvalid[3]), .dout(dout[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input int i, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] b);
    req[i] = 1'b1; wr[i] = 1'b1; addr[i] = a; din[i] = d; be[i] = b;
    @(posedge clk); #1;
    req[i] = 1'b0; wr[i] = 1'b0;
    check("wr_ready", 32'(ready[i]), 32'd1);
    check("wr_no_rvalid", 32'(rvalid[i]), 32'd0);
  endtask

  // Issue one read and verify the exact rvalid cycle and data.
  task automatic rd_word(input int i, input logic [5:0] a, input int lat,
                         input logic [31:0] exp);
    req[i] = 1'b1; wr[i] = 1'b0; addr[i] = a;
    @(posedge clk); #1;
    req[i] = 1'b0;
    for (int c = 1; c < lat; c++) begin
      check("rd_wait_ready", 32'(ready[i]), 32'd0);
      check("rd_wait_rvalid", 32'(rvalid[i]), 32'd0);
      @(posedge clk); #1;
    end
    check("rd_rvalid", 32'(rvalid[i]), 32'd1);
    check("rd_dout", dout[i], exp);
    @(posedge clk); #1;
    check("rd_rvalid_drop", 32'(rvalid[i]), 32'd0);
    check("rd_dout_hold", dout[i], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] exp_rv;
    logic [31:0] exp_be;
    rst = 1'b1; req = '0; wr = '0; addr = '0; din = '0; be = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'hF);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_dout0", dout[0], 32'h0);
    check("rst_dout3", dout[3], 32'h0);
    rst = 1'b0;

    // LAT=2 write then immediate read-back
    wr_word(0, 6'd5, 32'hDEADBEEF, 4'hF);
    rd_word(0, 6'd5, 2, 32'hDEADBEEF);

    // LAT=1 back-to-back reads
    wr_word(1, 6'd1, 32'h11, 4'hF);
    wr_word(1, 6'd2, 32'h22, 4'hF);
    wr_word(1, 6'd3, 32'h33, 4'hF);
    for (int j = 1; j <= 3; j++) begin
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 6'(j);
      @(posedge clk); #1;
      check("b2b_rvalid", 32'(rvalid[1]), 32'd1);
      check("b2b_ready", 32'(ready[1]), 32'd1);
      check("b2b_dout", dout[1], 32'h11 * j);
    end
    req[1] = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_rvalid", 32'(rvalid[1]), 32'd0);

    // Byte-enable write (be selects bytes 0 and 2)
    wr_word(0, 6'd7, 32'hFFFFFFFF, 4'hF);
    wr_word(0, 6'd7, 32'h00000000, 4'b0101);
`ifdef DMEM_BYTE_EN_EN
    exp_be = 32'hFF00FF00;
`else
    exp_be = 32'h00000000;
`endif
    rd_word(0, 6'd7, 2, exp_be);

    // LAT=4 reset abort
    wr_word(2, 6'd9, 32'hCAFE0004, 4'hF);
    wr_word(2, 6'd10, 32'hBEEF000A, 4'hF);
    rd_word(2, 6'd9, 4, 32'hCAFE0004);
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 6'd9;
    @(posedge clk); #1;
    req[2] = 1'b0;
    check("abort_accept_ready", 32'(ready[2]), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_rst_ready", 32'(ready[2]), 32'd1);
    check("abort_rst_rvalid", 32'(rvalid[2]), 32'd0);
    check("abort_rst_dout", dout[2], 32'h0);
    rst = 1'b0;
    // First edge after release accepts; no stale rvalid may appear meanwhile.
    rd_word(2, 6'd10, 4, 32'hBEEF000A);
    rd_word(2, 6'd9, 4, 32'hCAFE0004);

    // LAT=3 continuous requests; only reads seen while ready=1 are taken
    for (int a = 0; a < 10; a++) wr_word(3, 6'(a), 32'h100 + 32'(a), 4'hF);
    exp_rv = 12'h924;
    for (int j = 0; j < 12; j++) begin
      req[3] = (j < 10); wr[3] = 1'b0; addr[3] = 6'(j);
      @(posedge clk); #1;
      check("stream_rvalid", 32'(rvalid[3]), 32'(exp_rv[j]));
      check("stream_ready", 32'(ready[3]), 32'(exp_rv[j]));
      if (exp_rv[j]) check("stream_dout", dout[3], 32'h100 + 32'(j) - 32'd2);
    end
    req[3] = 1'b0;
    @(posedge clk); #1;
    check("stream_idle_rvalid", 32'(rvalid[3]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
